// File: rtl/regfile_pkg.sv
// Shared definitions for the operand-fetch slice: parameter defaults and the
// fetch-stage FSM encoding.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam bit          ZERO_REG_DEF = 1'b1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } fetch_state_t;

endpackage

// File: rtl/regfile_operand_fetch_if.sv
// Decode, execute, writeback and register-file signals of the operand-fetch
// stage. slave is the stage itself; master is its surroundings.
interface regfile_operand_fetch_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_rd_en;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op_a;
    logic [DATA_W-1:0] out_op_b;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_en;

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_raddr_a;
    logic [ADDR_W-1:0] rf_raddr_b;
    logic [DATA_W-1:0] rf_rdata_a;
    logic [DATA_W-1:0] rf_rdata_b;

    logic              init_done;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_en,
        output in_ready,
        output out_valid, out_op_a, out_op_b, out_rd, out_rd_en,
        input  out_ready,
        input  wb_valid, wb_rd, wb_data,
        output rf_we, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
        input  rf_rdata_a, rf_rdata_b,
        output init_done
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_en,
        input  in_ready,
        input  out_valid, out_op_a, out_op_b, out_rd, out_rd_en,
        output out_ready,
        output wb_valid, wb_rd, wb_data,
        input  rf_we, rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b,
        output rf_rdata_a, rf_rdata_b,
        input  init_done
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// One busy bit per register: set when a writer issues, cleared on writeback.
// A set and a clear of the same index in one cycle leaves the bit set.
module regfile_scoreboard #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              sync_clr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] src_a_idx,
    input  logic [ADDR_W-1:0] src_b_idx,
    input  logic [ADDR_W-1:0] dst_idx,
    output logic              src_a_busy,
    output logic              src_b_busy,
    output logic              dst_busy
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;

    // Clear applied first so a coincident set overrides it.
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (sync_clr) busy_q <= '0;
        else          busy_q <= busy_nxt;
    end

    assign src_a_busy = busy_q[src_a_idx];
    assign src_b_busy = busy_q[src_b_idx];
    assign dst_busy   = busy_q[dst_idx];

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage in front of the 2R1W register file: clears the file
// after reset, then issues instructions with scoreboard stalls and wb bypass.
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter bit          ZERO_REG = ZERO_REG_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_operand_fetch_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    fetch_state_t      state_q, state_nxt;
    logic [ADDR_W-1:0] sweep_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] op_a_q, op_b_q;
    logic [ADDR_W-1:0] rd_q;
    logic              rd_en_q;

    logic rs1_zero, rs2_zero, rd_zero, wb_zero;
    logic wb_hit_a, wb_hit_b, wb_hit_d;
    logic busy_a, busy_b, busy_d;
    logic haz_a, haz_b, haz_waw;
    logic running, in_ready, accept;
    logic [DATA_W-1:0] op_a_sel, op_b_sel;

    assign running  = (state_q == ST_RUN);

    assign rs1_zero = ZERO_REG && (bus.in_rs1 == '0);
    assign rs2_zero = ZERO_REG && (bus.in_rs2 == '0);
    assign rd_zero  = ZERO_REG && (bus.in_rd  == '0);
    assign wb_zero  = ZERO_REG && (bus.wb_rd  == '0);

    assign wb_hit_a = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
    assign wb_hit_b = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
    assign wb_hit_d = bus.wb_valid && (bus.wb_rd == bus.in_rd);

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .sync_clr   (rst),
        .set_en     (accept && bus.in_rd_en && !rd_zero),
        .set_idx    (bus.in_rd),
        .clr_en     (running && bus.wb_valid),
        .clr_idx    (bus.wb_rd),
        .src_a_idx  (bus.in_rs1),
        .src_b_idx  (bus.in_rs2),
        .dst_idx    (bus.in_rd),
        .src_a_busy (busy_a),
        .src_b_busy (busy_b),
        .dst_busy   (busy_d)
    );

    // A writeback arriving this cycle resolves the hazard it was blocking.
    assign haz_a   = busy_a && !wb_hit_a && !rs1_zero;
    assign haz_b   = busy_b && !wb_hit_b && !rs2_zero;
    assign haz_waw = bus.in_rd_en && busy_d && !wb_hit_d;

    assign in_ready = !rst && running && !(haz_a || haz_b || haz_waw)
                      && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_nxt = state_q;
        if (state_q == ST_INIT && sweep_q == LAST_ADDR) state_nxt = ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
        end
    end

    always_comb begin
        op_a_sel = bus.rf_rdata_a;
        op_b_sel = bus.rf_rdata_b;
        if (rs1_zero)      op_a_sel = '0;
        else if (wb_hit_a) op_a_sel = bus.wb_data;
        if (rs2_zero)      op_b_sel = '0;
        else if (wb_hit_b) op_b_sel = bus.wb_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op_a_q      <= op_a_sel;
            op_b_q      <= op_b_sel;
            rd_q        <= bus.in_rd;
            rd_en_q     <= bus.in_rd_en;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Register-file write port: clear sweep in INIT, writeback in RUN.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = bus.wb_rd;
        bus.rf_wdata = bus.wb_data;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                bus.rf_we    = 1'b1;
                bus.rf_waddr = sweep_q;
                bus.rf_wdata = '0;
            end else begin
                bus.rf_we    = bus.wb_valid && !wb_zero;
            end
        end
    end

    assign bus.rf_raddr_a = bus.in_rs1;
    assign bus.rf_raddr_b = bus.in_rs2;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_op_a   = op_a_q;
    assign bus.out_op_b   = op_b_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_rd_en  = rd_en_q;
    assign bus.init_done  = running;

endmodule
